// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter.
// MAX_ADDR is the highest byte address that still fits a full access.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int MEM_BYTES    = 301;
    localparam int ACCESS_BYTES = 4;
    localparam int MAX_ADDR     = MEM_BYTES - ACCESS_BYTES;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: on a tie the port not granted
// last time wins, otherwise the lone requester wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       valid
);

    assign valid = |req;
    assign gnt   = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MEM stage (port 0) and the
// array loader (port 1); one 32-bit access per IDLE/ACCESS/DONE pass.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MEM_BYTES    = dmem_arb_pkg::MEM_BYTES,
    parameter int ACCESS_BYTES = dmem_arb_pkg::ACCESS_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Write_Data,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] Read_Data
);

    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - ACCESS_BYTES);

    state_t state;
    logic   gid;
    logic   lat_we;
    logic   lat_err;
    logic   last_grant;

    logic              pick;
    logic              pick_v;
    logic              req_we;
    logic              req_oor;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_next;
    logic              unused_rd;

    rr_pick2 u_pick (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .gnt        (pick),
        .valid      (pick_v)
    );

    assign req_we    = pick ? p1_we    : p0_we;
    assign req_addr  = pick ? p1_addr  : p0_addr;
    assign req_wdata = pick ? p1_wdata : p0_wdata;
    assign req_oor   = req_addr > LAST_OK;

    // Only the low word is memory data; the upper half reads as zero.
    assign rd_word   = {{(DATA_W-32){1'b0}}, Read_Data[31:0]};
    assign rd_next   = lat_err ? '0 : rd_word;
    assign unused_rd = ^Read_Data[DATA_W-1:32];

    assign busy = (state != IDLE);

    // Memory-side strobes are registered so async reset drops them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gid        <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            last_grant <= 1'b1;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
            Mem_Addr   <= '0;
            Write_Data <= '0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_v) begin
                        gid        <= pick;
                        lat_we     <= req_we;
                        lat_err    <= req_oor;
                        Mem_Addr   <= req_addr;
                        Write_Data <= req_wdata;
                        MemWrite   <= req_we & ~req_oor;
                        MemRead    <= ~req_we & ~req_oor;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    Mem_Addr   <= '0;
                    Write_Data <= '0;
                    MemWrite   <= 1'b0;
                    MemRead    <= 1'b0;
                    if (lat_err || !lat_we) begin
                        if (gid) p1_rdata <= rd_next;
                        else     p0_rdata <= rd_next;
                    end
                    if (gid) begin
                        p1_ack <= 1'b1;
                        p1_err <= lat_err;
                    end else begin
                        p0_ack <= 1'b1;
                        p0_err <= lat_err;
                    end
                    state <= DONE;
                end
                DONE: begin
                    last_grant <= gid;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, tie, back-to-back and
// reset-abort sequences against a byte-array memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [63:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [63:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err, busy;
    logic [63:0] p0_rdata, p1_rdata;
    logic [63:0] Mem_Addr, Write_Data, Read_Data;
    logic        MemWrite, MemRead;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p0_ack     (p0_ack),
        .p0_err     (p0_err),
        .p0_rdata   (p0_rdata),
        .p1_ack     (p1_ack),
        .p1_err     (p1_err),
        .p1_rdata   (p1_rdata),
        .busy       (busy),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    typedef struct {
        bit          port;
        bit          err;
        bit          chk_rd;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          err;
        bit          chk_rd;
        logic [63:0] rdata;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vt[10];

    logic [7:0] mem [0:300];

    initial for (int i = 0; i < 301; i++) mem[i] = 8'(i);

    always @(posedge clk)
        if (MemWrite && Mem_Addr <= 64'd297)
            for (int i = 0; i < 4; i++)
                mem[int'(Mem_Addr[8:0]) + i] <= Write_Data[8*i +: 8];

    // Upper half and out-of-range reads return junk the DUT must not pass on.
    always_comb begin
        Read_Data = 64'hFFFF_FFFF_BAD0_BAD0;
        if (Mem_Addr <= 64'd297)
            Read_Data[31:0] = {mem[int'(Mem_Addr[8:0]) + 3],
                               mem[int'(Mem_Addr[8:0]) + 2],
                               mem[int'(Mem_Addr[8:0]) + 1],
                               mem[int'(Mem_Addr[8:0])]};
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            strobes = 0;
        end else begin
            if (MemWrite || MemRead) strobes++;
            if (p0_ack || p1_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {62'b0, p1_ack, p0_ack}, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("ack_port", {62'b0, p1_ack, p0_ack},
                        cur.port ? 64'd2 : 64'd1);
                    chk("err", {63'b0, cur.port ? p1_err : p0_err},
                        {63'b0, cur.err});
                    if (cur.chk_rd)
                        chk("rdata", cur.port ? p1_rdata : p0_rdata, cur.rdata);
                    chk("strobes", 64'(strobes), cur.err ? 64'd0 : 64'd1);
                end
                strobes = 0;
            end
        end
    end

    task automatic drive(bit port, bit we, logic [63:0] addr, logic [63:0] wd);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end
    endtask

    task automatic run_vec(vec_t v);
        int k;
        sb.push_back('{v.port, v.err, v.chk_rd, v.rdata});
        @(posedge clk);
        #1 drive(v.port, v.we, v.addr, v.wdata);
        @(posedge clk);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (v.port ? p1_ack : p0_ack) break;
        end
        chk("latency", 64'(k), 64'd1);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin
        int n0, n1, a1, a2;

        vt[0] = '{1, 1, 64'd8,   64'hDEADBEEF,            0, 0, 64'h0};
        vt[1] = '{1, 0, 64'd8,   64'h0,                   0, 1, 64'h0000_0000_DEAD_BEEF};
        vt[2] = '{0, 0, 64'd298, 64'h0,                   1, 1, 64'h0};
        vt[3] = '{0, 1, 64'd297, 64'h1122_3344,           0, 0, 64'h0};
        vt[4] = '{0, 0, 64'd297, 64'h0,                   0, 1, 64'h1122_3344};
        vt[5] = '{1, 1, 64'd0,   64'hFFFF_FFFF_A5A5_A5A5, 0, 0, 64'h0};
        vt[6] = '{1, 0, 64'd0,   64'h0,                   0, 1, 64'h0000_0000_A5A5_A5A5};
        vt[7] = '{0, 0, 64'h1_0000_0008, 64'h0,           1, 1, 64'h0};
        vt[8] = '{1, 1, 64'd300, 64'h1234_5678,           1, 0, 64'h0};
        vt[9] = '{0, 0, 64'd8,   64'h0,                   0, 1, 64'h0000_0000_DEAD_BEEF};

        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_acks", {60'b0, p0_ack, p1_ack, p0_err, p1_err}, 64'd0);
        chk("rst_strobes", {62'b0, MemWrite, MemRead}, 64'd0);
        chk("rst_mem_addr", Mem_Addr, 64'd0);
        chk("rst_wdata", Write_Data, 64'd0);
        chk("rst_p0_rdata", p0_rdata, 64'd0);
        chk("rst_p1_rdata", p1_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Tie from reset: p0 keeps requesting after its first ack.
        sb.push_back('{0, 0, 1, 64'h0706_0504});
        sb.push_back('{1, 0, 1, 64'h0F0E_0D0C});
        sb.push_back('{0, 0, 1, 64'h1312_1110});
        @(posedge clk);
        #1;
        drive(0, 0, 64'd4, 64'h0);
        drive(1, 0, 64'd12, 64'h0);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 30 && (p0_req || p1_req); k++) begin
            @(negedge clk);
            if (p0_ack) begin
                n0++;
                if (n0 == 1) p0_addr = 64'd16;
                else         p0_req = 1'b0;
            end
            if (p1_ack) begin
                n1++;
                p1_req = 1'b0;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("tie_p0_acks", 64'(n0), 64'd2);
        chk("tie_p1_acks", 64'(n1), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // Back-to-back on p0 with req held across the ack.
        sb.push_back('{0, 0, 1, 64'h0F0E_0D0C});
        sb.push_back('{0, 0, 1, 64'h1312_1110});
        @(posedge clk);
        #1 drive(0, 0, 64'd12, 64'h0);
        @(posedge clk);
        a1 = -1;
        a2 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p0_ack) begin
                if (a1 < 0) begin
                    a1 = k + 1;
                    p0_addr = 64'd16;
                end else begin
                    a2 = k + 1;
                    p0_req = 1'b0;
                    break;
                end
            end
        end
        p0_req = 1'b0;
        chk("b2b_ack1_cycle", 64'(a1), 64'd2);
        chk("b2b_ack2_cycle", 64'(a2), 64'd5);

        // Reset lands inside the ACCESS cycle of a write.
        @(posedge clk);
        #1 drive(1, 1, 64'd20, 64'hCAFE_F00D);
        @(posedge clk);
        #1 chk("abort_in_access", {63'b0, MemWrite}, 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_memwrite", {62'b0, MemWrite, MemRead}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_mem_addr", Mem_Addr, 64'd0);
        chk("abort_wdata", Write_Data, 64'd0);
        chk("abort_acks", {60'b0, p0_ack, p1_ack, p0_err, p1_err}, 64'd0);
        chk("abort_p0_rdata", p0_rdata, 64'd0);
        chk("abort_p1_rdata", p1_rdata, 64'd0);
        p1_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_mem_bytes", {32'b0, mem[23], mem[22], mem[21], mem[20]},
            64'h1716_1514);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory. It shares the single memory port between the pipeline MEM stage (port 0) and the array loader/checker that preloads and reads back the bubble-sort array (port 1). Each transaction is a 32-bit little-endian access issued through a req/ack handshake. The block applies round-robin fairness, bounds-checks addresses and registers read data.

## Interface
Parameters:
- ADDR_W, 64, address width on all ports
- DATA_W, 64, data width on all ports; only [31:0] carries data
- MEM_BYTES, 301, memory size in bytes
- ACCESS_BYTES, 4, bytes per access

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- p0_req, p1_req  in  1  request valid, held until ack
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W  byte address
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_err, p1_err  out  1  out-of-range flag, valid with ack
- p0_rdata, p1_rdata  out  DATA_W  read result, held until that port's next ack
- busy  out  1  high whenever state ≠ IDLE
- Mem_Addr  out  ADDR_W  to memory
- Write_Data  out  DATA_W  to memory
- MemWrite, MemRead  out  1  to memory
- Read_Data  in  DATA_W  combinational read data from memory

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE: if any req is high, pick a winner, latch its we/addr/wdata and grant id, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration: if only one port requests, that port wins. If both request, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS: drive Mem_Addr and Write_Data from the latch. Assert MemWrite (write) or MemRead (read) for exactly this one cycle. On the closing edge:
  - a write commits bytes addr..addr+3;
  - a read captures Read_Data[31:0] into the granted port's rdata, with [63:32] set to 0.
  - Then go to DONE.
- Range check: if addr > MEM_BYTES − ACCESS_BYTES (i.e. > 297), MemWrite and MemRead stay 0 in ACCESS, rdata is loaded with 0, and err is set.
- DONE: pulse the granted port's ack, plus err if flagged. Update last_grant. Go to IDLE.
- Outside ACCESS, Mem_Addr, Write_Data, MemWrite and MemRead are all 0.
- Requester rule: req may stay high in the cycle after ack, which is IDLE. In that cycle it is treated as a new request, so a requester must either drop req or present its next transaction there.
- Request fields must stay stable from req assertion until ack. The block latches them at grant, so later changes are ignored.

## Timing
- Reset values: state = IDLE, last_grant = 1. All acks, errs, rdata, memory-side outputs and busy are 0.
- Latency: req high at edge N (IDLE) → ACCESS during cycle N+1 → ack during cycle N+2.
- Throughput: one access per 3 cycles. Back-to-back requests from both ports alternate grants.
- Simultaneous events: a req arriving during ACCESS or DONE waits. It is arbitrated at the first IDLE edge.
- Reset mid-operation: asserting reset forces MemWrite low immediately (asynchronous). A write whose ACCESS edge coincides with or follows reset assertion is not committed. No ack is issued for an aborted transaction.
- Address arithmetic: the range check uses the full ADDR_W unsigned compare, so addresses with upper bits set are out of range. addr + ACCESS_BYTES never wraps.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, DONE};
  - the MEM_BYTES and ACCESS_BYTES defaults;
  - a MAX_ADDR constant equal to MEM_BYTES − ACCESS_BYTES.
- One sub-module, rr_pick2: a two-input round-robin picker. It takes req[1:0] and last_grant and returns a grant index and a valid flag; it is purely combinational.
- The top level holds the FSM, the request latch, the two rdata registers and the memory-side muxing.

## Test plan
- Single write/read on port 1: write 0xDEADBEEF to addr 8, then read addr 8. p1_ack 2 cycles after each req; p1_rdata = 0x00000000DEADBEEF; p1_err = 0.
- Tie: p0 and p1 both request from reset. Order is p0 then p1 then p0. MemWrite/MemRead high exactly 1 cycle per grant.
- Out of range: p0 reads addr 298. Then p0_ack and p0_err both go high, p0_rdata = 0, and MemRead never asserts. Addr 297 succeeds with err = 0.
- Back-to-back: p0 holds req through ack with a new addr (12 then 16). Two transactions complete; ack is seen at cycles 2 and 5.
- Reset during ACCESS of a write to addr 20: memory bytes 20–23 stay unchanged, no ack, and all outputs return to reset values immediately.
